// File: rtl/vector_exec_pkg.sv
// Shared types and constants for the vector execute pipeline.
// The optional build macro VEC_SAT_EN uses sat_clamp for ADD/SUB/MUL saturation.
package vector_exec_pkg;

  localparam int LANES   = 4;
  localparam int WIDTH   = 16;
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_PASS_A = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_XOR    = 3'd3,
    OP_SLL    = 3'd4,
    OP_SRL    = 3'd5,
    OP_ROTL   = 3'd6,
    OP_MUL    = 3'd7
  } vec_op_e;

  typedef logic [WIDTH-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;

  // Most negative value when neg is set, otherwise the most positive value.
  function automatic lane_t sat_clamp(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// One combinational vector lane: result and signed-overflow flag for a single opcode.
// Build macro VEC_SAT_EN: overflowing ADD/SUB/MUL lanes saturate instead of wrapping.
module vector_lane_alu
  import vector_exec_pkg::*;
(
  input  vec_op_e op,
  input  lane_t   a,
  input  lane_t   b,
  output lane_t   result,
  output logic    ovf
);

  logic [SHAMT_W-1:0]          sh;
  lane_t                       sum;
  lane_t                       diff;
  logic [2*WIDTH-1:0]          rot;
  logic signed [2*WIDTH-1:0]   ax;
  logic signed [2*WIDTH-1:0]   bx;
  logic signed [2*WIDTH-1:0]   prod;
  logic                        add_ovf;
  logic                        sub_ovf;
  logic                        mul_ovf;

  always_comb begin
    sh   = b[SHAMT_W-1:0];
    sum  = a + b;
    diff = a - b;
    rot  = {a, a} << sh;
    ax   = {{WIDTH{a[WIDTH-1]}}, a};
    bx   = {{WIDTH{b[WIDTH-1]}}, b};
    prod = ax * bx;
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension.
    mul_ovf = (|prod[2*WIDTH-1:WIDTH-1]) && !(&prod[2*WIDTH-1:WIDTH-1]);

    result = a;
    ovf    = 1'b0;
    case (op)
      OP_PASS_A: result = a;
      OP_ADD: begin
        ovf = add_ovf;
`ifdef VEC_SAT_EN
        result = add_ovf ? sat_clamp(a[WIDTH-1]) : sum;
`else
        result = sum;
`endif
      end
      OP_SUB: begin
        ovf = sub_ovf;
`ifdef VEC_SAT_EN
        result = sub_ovf ? sat_clamp(a[WIDTH-1]) : diff;
`else
        result = diff;
`endif
      end
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << sh;
      OP_SRL:  result = a >> sh;
      OP_ROTL: result = rot[2*WIDTH-1:WIDTH];
      OP_MUL: begin
        ovf = mul_ovf;
`ifdef VEC_SAT_EN
        result = mul_ovf ? sat_clamp(prod[2*WIDTH-1]) : prod[WIDTH-1:0];
`else
        result = prod[WIDTH-1:0];
`endif
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/vector_exec_pipeline.sv
// Elastic vector execute unit: LANES lane ALUs feeding a STAGES-deep valid/ready register chain.
// Build macro VEC_SAT_EN selects saturating ADD/SUB/MUL inside vector_lane_alu.
module vector_exec_pipeline
  import vector_exec_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_ovf,
  output logic                   out_zero,
  output logic [31:0]            retired_count
);

  vec_t             a_v;
  vec_t             b_v;
  vec_t             alu_res;
  logic [LANES-1:0] alu_ovf;
  vec_op_e          op;

  assign a_v = in_a;
  assign b_v = in_b;
  assign op  = vec_op_e'(in_op);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vector_lane_alu u_alu (
      .op     (op),
      .a      (a_v[gi]),
      .b      (b_v[gi]),
      .result (alu_res[gi]),
      .ovf    (alu_ovf[gi])
    );
  end

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];
  vec_t             res_q   [STAGES];
  vec_t             res_d   [STAGES];
  logic [LANES-1:0] ovf_q   [STAGES];
  logic [LANES-1:0] ovf_d   [STAGES];
  logic             zero_q  [STAGES];
  logic             zero_d  [STAGES];
  logic [STAGES-1:0] load;
  logic             chain;
  logic             accept;
  logic             handoff;
  logic [31:0]      retired_count_q;
  logic [31:0]      retired_count_d;

  always_comb begin
    // Ready ripples back from out_ready; an empty stage breaks the chain so bubbles collapse.
    chain = !valid_q[STAGES-1] || out_ready;
    load  = '0;
    load[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain   = !valid_q[k] || chain;
      load[k] = chain;
    end
    in_ready = !flush && load[0];
    accept   = in_valid && in_ready;
    handoff  = valid_q[STAGES-1] && out_ready && !flush;
    retired_count_d = retired_count_q + (handoff ? 32'd1 : 32'd0);

    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      tag_d[k]   = tag_q[k];
      res_d[k]   = res_q[k];
      ovf_d[k]   = ovf_q[k];
      zero_d[k]  = zero_q[k];
    end

    if (flush) begin
      for (int k = 0; k < STAGES; k++) valid_d[k] = 1'b0;
    end else begin
      if (load[0]) begin
        valid_d[0] = accept;
        if (accept) begin
          tag_d[0]  = in_tag;
          res_d[0]  = alu_res;
          ovf_d[0]  = alu_ovf;
          zero_d[0] = (alu_res == '0);
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            tag_d[k]  = tag_q[k-1];
            res_d[k]  = res_q[k-1];
            ovf_d[k]  = ovf_q[k-1];
            zero_d[k] = zero_q[k-1];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[gi] <= 1'b0;
        tag_q[gi]   <= '0;
        res_q[gi]   <= '0;
        ovf_q[gi]   <= '0;
        zero_q[gi]  <= 1'b0;
      end else begin
        valid_q[gi] <= valid_d[gi];
        tag_q[gi]   <= tag_d[gi];
        res_q[gi]   <= res_d[gi];
        ovf_q[gi]   <= ovf_d[gi];
        zero_q[gi]  <= zero_d[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_count_q <= '0;
    else     retired_count_q <= retired_count_d;
  end

  assign out_valid     = valid_q[STAGES-1];
  assign out_tag       = tag_q[STAGES-1];
  assign out_result    = res_q[STAGES-1];
  assign out_ovf       = ovf_q[STAGES-1];
  assign out_zero      = zero_q[STAGES-1];
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_vector_exec_pipeline.sv
// Scoreboard bench for vector_exec_pipeline (LANES=4, WIDTH=16, STAGES=3); honours VEC_SAT_EN.
module tb_vector_exec_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_tag;
  logic [63:0] out_result;
  logic [3:0]  out_ovf;
  logic        out_zero;
  logic [31:0] retired_count;

  vector_exec_pipeline dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_tag        (in_tag),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_tag       (out_tag),
    .out_result    (out_result),
    .out_ovf       (out_ovf),
    .out_zero      (out_zero),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] res;
    logic [3:0]  ovf;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent lane model using integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic [3:0] ovf);
    res = '0;
    ovf = '0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] la, lb, r;
      int sa, sb_i, ua, ub, full, tmp, sh;
      logic o;
      la = a[i*16 +: 16];
      lb = b[i*16 +: 16];
      sa = $signed(la);
      sb_i = $signed(lb);
      ua = int'(la);
      ub = int'(lb);
      sh = ub % 16;
      o = 1'b0;
      full = 0;
      r = la;
      case (op)
        3'd0: r = la;
        3'd1, 3'd2, 3'd7: begin
          if (op == 3'd1) full = sa + sb_i;
          else if (op == 3'd2) full = sa - sb_i;
          else full = sa * sb_i;
          o = (full > 32767) || (full < -32768);
          r = full[15:0];
`ifdef VEC_SAT_EN
          if (o) r = (full < 0) ? 16'h8000 : 16'h7FFF;
`endif
        end
        3'd3: r = la ^ lb;
        3'd4: begin tmp = ua << sh; r = tmp[15:0]; end
        3'd5: begin tmp = ua >> sh; r = tmp[15:0]; end
        default: begin tmp = (ua << sh) | (ua >> (16 - sh)); r = tmp[15:0]; end
      endcase
      res[i*16 +: 16] = r;
      ovf[i] = o;
    end
  endfunction

  // Scoreboard: push on accept, pop and compare on handoff.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_ret = 32'd0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("retired_before_handoff", retired_count, exp_ret);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("out_tag", out_tag, e.tag);
          check("out_result", out_result, e.res);
          check("out_ovf", out_ovf, e.ovf);
          check("out_zero", out_zero, e.zero);
          $display("retire tag=%0d result=%h ovf=%b zero=%b", out_tag, out_result, out_ovf, out_zero);
        end
        exp_ret++;
      end
      if (in_valid && in_ready) begin
        model(in_op, in_a, in_b, e.res, e.ovf);
        e.tag  = in_tag;
        e.zero = (e.res == 64'd0);
        sb.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b);
    logic rdy;
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    in_a     = a;
    in_b     = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    in_valid = 1'b0;
    if (!rdy) check("send_timeout", in_ready, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  logic [2:0]  tbl_op [8];
  logic [63:0] tbl_a  [8];
  logic [63:0] tbl_b  [8];
  logic [31:0] ret_snap;
  int          acc_snap;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_retired", retired_count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_zero", out_zero, 0);
    check("reset_out_tag", out_tag, 0);

    // 1. ADD with latency check
    send(3'd1, 4'd5, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
    check("lat_edge_n", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge_n1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge_n2", out_valid, 1);
    check("add_result", out_result, 64'h002C_0021_0016_000B);
    check("add_tag", out_tag, 5);
    check("add_ovf", out_ovf, 0);
    check("add_zero", out_zero, 0);
    @(posedge clk); #1;
    check("add_retired", retired_count, 1);

    // 2/3. Overflow, multiply, shifts, rotate, xor-to-zero
    tbl_op[0] = 3'd1; tbl_a[0] = 64'h0001_8000_0005_7FFF; tbl_b[0] = 64'h0001_FFFF_0006_0001;
    tbl_op[1] = 3'd7; tbl_a[1] = 64'h012C_012C_012C_012C; tbl_b[1] = 64'h012C_012C_012C_012C;
    tbl_op[2] = 3'd6; tbl_a[2] = 64'h1234_0001_FFFF_8001; tbl_b[2] = 64'h0004_000F_0003_0001;
    tbl_op[3] = 3'd4; tbl_a[3] = 64'h00FF_0003_0001_0001; tbl_b[3] = 64'h0008_0000_0001_000F;
    tbl_op[4] = 3'd5; tbl_a[4] = 64'hFFFF_1234_8000_8000; tbl_b[4] = 64'h0004_0000_0001_000F;
    tbl_op[5] = 3'd3; tbl_a[5] = 64'hAAAA_AAAA_AAAA_AAAA; tbl_b[5] = 64'hAAAA_AAAA_AAAA_AAAA;
    tbl_op[6] = 3'd2; tbl_a[6] = 64'h8000_7FFF_0000_0005; tbl_b[6] = 64'h0001_FFFF_0001_0007;
    tbl_op[7] = 3'd0; tbl_a[7] = 64'hDEAD_BEEF_0000_1111; tbl_b[7] = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 8; i++) send(tbl_op[i], 4'(i + 1), tbl_a[i], tbl_b[i]);
    wait_drain();

    // 4. Backpressure: only STAGES ops accepted, output held
    out_ready = 1'b0;
    acc_snap  = n_acc;
    ret_snap  = retired_count;
    fork
      for (int i = 0; i < 5; i++) send(3'd1, 4'(8 + i), 64'(i), 64'h0001_0001_0001_0001);
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_accepted", n_acc - acc_snap, 3);
    check("stall_out_valid", out_valid, 1);
    check("stall_tag_a", out_tag, 8);
    @(negedge clk);
    check("stall_tag_b", out_tag, 8);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    wait_drain();
    @(posedge clk); #1;
    check("bp_retired", retired_count - ret_snap, 5);

    // 5. Flush with two ops in flight and a presented op
    send(3'd1, 4'd1, 64'h1, 64'h1);
    send(3'd1, 4'd2, 64'h2, 64'h2);
    ret_snap = retired_count;
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'd3; in_op = 3'd0; in_a = 64'h3;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    check("flush_out_valid_later", out_valid, 0);
    check("flush_retired", retired_count, ret_snap);

    // Result presented in the flush cycle with out_ready=1 is not retired
    out_ready = 1'b0;
    send(3'd3, 4'd4, 64'hF, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("flush2_presented", out_valid, 1);
    ret_snap = retired_count;
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush2_out_valid", out_valid, 0);
    check("flush2_retired", retired_count, ret_snap);

    // 6. Asynchronous reset mid-cycle with a stalled full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd1, 4'(12 + i), 64'h5, 64'h5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_retired", retired_count, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(3'd7, 4'd9, 64'h0003_0002_FFFF_0007, 64'h0003_0002_0002_0006);
    @(posedge clk); #1;
    check("post_rst_lat_n1", out_valid, 0);
    @(posedge clk); #1;
    check("post_rst_lat_n2", out_valid, 1);
    check("post_rst_tag", out_tag, 9);

    // Random ops under random backpressure
    fork
      for (int i = 0; i < 30; i++)
        send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             {$urandom, $urandom}, {$urandom, $urandom});
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
